frame_packer: RTL
=================

// Module: frame_packer
// PURPOSE
//   Downstream consumer of the mode_selector byte stream (data[7:0], one byte per clk).
//   Buffers incoming bytes in an internal FIFO and emits fixed-length frames:
//   header byte, PAY_LEN payload bytes, then an 8-bit checksum.
//   Output uses a valid/ready handshake so a slower sink (UART/logger) can stall it.
// PARAMETERS
//   DEPTH    16     FIFO depth in bytes, power of 2, >= PAY_LEN
//   PAY_LEN  4      payload bytes per frame, 1..DEPTH
//   HDR      8'hA5  header byte sent first in every frame
// PORTS
//   clk        in   1  system clock, all logic on posedge
//   xrst       in   1  asynchronous active-low reset
//   in_en      in   1  capture in_data this cycle
//   in_data    in   8  byte from mode_selector.data
//   out_data   out  8  frame byte
//   out_valid  out  1  out_data valid
//   out_ready  in   1  sink accepts byte when out_valid & out_ready
//   out_sof    out  1  high with the header byte
//   out_eof    out  1  high with the checksum byte
//   fifo_lvl   out  $clog2(DEPTH)+1  current FIFO occupancy
//   drop_cnt   out  8  bytes dropped on overflow, saturates at 8'hFF
// BEHAVIOUR
//   Reset (xrst=0, async): FSM=IDLE, FIFO empty, fifo_lvl=0, out_data=8'h00,
//     out_valid=0, out_sof=0, out_eof=0, drop_cnt=0, checksum acc=0.
//     Reset mid-frame discards the partial frame and all buffered bytes.
//   Push: in_en=1 and (fifo_lvl<DEPTH or a pop occurs same cycle) -> byte written.
//     in_en=1 with FIFO full and no same-cycle pop -> byte dropped, drop_cnt+1 (sat).
//   Pop: only in PAY state on an accepted transfer; push+pop same cycle -> lvl unchanged.
//   FSM (registered outputs; transfer = out_valid & out_ready):
//     IDLE: out_valid=0. If fifo_lvl>=PAY_LEN -> HDR next cycle. Whole payload
//       is buffered before a frame starts, so payload never has bubbles.
//     HDR : out_data=HDR, out_sof=1, out_valid=1; on transfer -> PAY, acc=0.
//     PAY : out_data=FIFO head, out_valid=1; on transfer pop, acc=acc+byte
//       (mod 256), idx+1; after PAY_LEN-th transfer -> SUM.
//     SUM : out_data=acc (incl. last byte), out_eof=1, out_valid=1; on transfer
//       -> IDLE, or directly HDR if fifo_lvl>=PAY_LEN (back-to-back frames).
//   Handshake: once out_valid=1, out_data/out_sof/out_eof hold stable until
//     transfer; out_valid never drops without a transfer (except reset).
//   Latency: lvl reaches PAY_LEN at cycle N -> HDR presented with out_valid at N+1.
//   Throughput: with out_ready=1 a frame is PAY_LEN+2 cycles; input at 1 byte/clk
//     exceeds this, so sustained overflow is expected and counted, never corrupts.
//   Checksum: 8-bit unsigned sum, carries discarded.
//   Pointers wrap modulo DEPTH; fifo_lvl range 0..DEPTH inclusive.
// TESTING (PAY_LEN=4, DEPTH=16, HDR=A5)
//   1. push 01,02,03,04, out_ready=1 -> A5(sof),01,02,03,04,0A(eof); lvl ends 0.
//   2. push FF x4 -> checksum FC (wrap); push 80,80,00,00 -> checksum 00.
//   3. out_ready toggled 1/0 each cycle during frame -> same byte sequence,
//      out_data stable while out_valid=1 & out_ready=0.
//   4. out_ready=0, push 20 bytes -> lvl=16, drop_cnt=4; release -> 4 frames of
//      first 16 bytes in order, back-to-back, no IDLE gap.
//   5. push 3 bytes only -> no out_valid; 4th byte -> HDR one cycle later.
//   6. xrst low during PAY -> all outputs reset values, lvl=0; next frame clean.

Source files
------------

// File: rtl/frame_packer.sv
// frame_packer
// Buffers the byte stream from mode_selector in a small FIFO and re-emits it
// as fixed-length frames:
//     header byte, PAY_LEN payload bytes, 8-bit checksum of the payload
// on a valid/ready interface so that a slow sink can stall the output.
// A frame is only started once its whole payload is already buffered, so the
// payload phase never has to wait for input and never shows a bubble.

module frame_packer #(
    parameter int         DEPTH   = 16,     // FIFO depth in bytes, power of 2, >= PAY_LEN
    parameter int         PAY_LEN = 4,      // payload bytes per frame
    parameter logic [7:0] HDR     = 8'hA5   // first byte of every frame
) (
    input  logic                   clk,
    input  logic                   xrst,
    input  logic                   in_en,
    input  logic [7:0]             in_data,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic [$clog2(DEPTH):0] fifo_lvl,
    output logic [7:0]             drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int IDX_W = (PAY_LEN > 1) ? $clog2(PAY_LEN) : 1;

    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_FRAME = LVL_W'(PAY_LEN);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAY_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_SUM  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]       mem [DEPTH];
    logic [7:0]       head_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [LVL_W-1:0] lvl_reg;
    logic [LVL_W-1:0] lvl_next;
    logic [7:0]       drop_reg;
    logic [7:0]       drop_next;

    // ------------------------------------------------------------------
    // Frame sequencer state; every output comes straight from a register
    // ------------------------------------------------------------------
    state_t           state_reg;
    logic [7:0]       byte_reg;    // header / checksum / idle byte
    logic             valid_reg;
    logic             sof_reg;
    logic             eof_reg;
    logic [7:0]       acc_reg;     // running payload checksum
    logic [IDX_W-1:0] idx_reg;     // payload byte index inside the frame

    logic             xfer;
    logic             pop;
    logic             push;
    logic             full;
    logic             frame_avail;
    logic [7:0]       pay_sum;

    // Handshake decode and FIFO next-state arithmetic
    always_comb begin
        xfer        = valid_reg & out_ready;
        // Only payload bytes leave the FIFO; header and checksum are generated.
        pop         = (state_reg == ST_PAY) & xfer;
        full        = (lvl_reg == LVL_FULL);
        // A full FIFO still accepts a byte when a slot frees up in the same cycle.
        push        = in_en & (~full | pop);
        frame_avail = (lvl_reg >= LVL_FRAME);
        // Checksum including the byte currently on the bus (8-bit wrap).
        pay_sum     = acc_reg + head_reg;

        wr_ptr_next = push ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
        rd_ptr_next = pop  ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;

        lvl_next = lvl_reg;
        if (push && !pop) begin
            lvl_next = lvl_reg + LVL_ONE;
        end else if (pop && !push) begin
            lvl_next = lvl_reg - LVL_ONE;
        end

        // Overflow counter saturates so a long stall never wraps it to a small value.
        drop_next = drop_reg;
        if (in_en && !push && (drop_reg != 8'hFF)) begin
            drop_next = drop_reg + 8'd1;
        end
    end

    // Byte storage with a registered read port addressed by the next read pointer,
    // so head_reg always holds the byte that is at the head after this edge.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
        head_reg <= mem[rd_ptr_next];
    end

    // FIFO pointers, occupancy and overflow counter
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            lvl_reg    <= '0;
            drop_reg   <= 8'h00;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            lvl_reg    <= lvl_next;
            drop_reg   <= drop_next;
        end
    end

    // Frame sequencer: header, payload drained from the FIFO, then checksum
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_reg <= ST_IDLE;
            byte_reg  <= 8'h00;
            valid_reg <= 1'b0;
            sof_reg   <= 1'b0;
            eof_reg   <= 1'b0;
            acc_reg   <= 8'h00;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Wait for a complete payload so the frame can stream without gaps.
                    if (frame_avail) begin
                        state_reg <= ST_HDR;
                        byte_reg  <= HDR;
                        valid_reg <= 1'b1;
                        sof_reg   <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        state_reg <= ST_PAY;
                        byte_reg  <= 8'h00;
                        sof_reg   <= 1'b0;
                        acc_reg   <= 8'h00;
                        idx_reg   <= '0;
                    end
                end
                ST_PAY: begin
                    // Payload byte is head_reg; it only advances on an accepted transfer.
                    if (xfer) begin
                        acc_reg <= pay_sum;
                        if (idx_reg == IDX_LAST) begin
                            state_reg <= ST_SUM;
                            byte_reg  <= pay_sum;
                            eof_reg   <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + IDX_ONE;
                        end
                    end
                end
                ST_SUM: begin
                    if (xfer) begin
                        eof_reg <= 1'b0;
                        // Chain straight into the next header when a payload is ready.
                        if (frame_avail) begin
                            state_reg <= ST_HDR;
                            byte_reg  <= HDR;
                            sof_reg   <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                            byte_reg  <= 8'h00;
                            valid_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    byte_reg  <= 8'h00;
                    valid_reg <= 1'b0;
                    sof_reg   <= 1'b0;
                    eof_reg   <= 1'b0;
                end
            endcase
        end
    end

    // During the payload the bus shows the FIFO head, otherwise the sequencer byte.
    assign out_data  = (state_reg == ST_PAY) ? head_reg : byte_reg;
    assign out_valid = valid_reg;
    assign out_sof   = sof_reg;
    assign out_eof   = eof_reg;
    assign fifo_lvl  = lvl_reg;
    assign drop_cnt  = drop_reg;

endmodule
